ber_stats_reader: RTL

Read-side counterpart to the BER counter block: it captures a coherent snapshot of the five 64-bit error-statistics counters and streams the snapshot out as 32-bit words over a valid/ready interface. It sits between the parallel FEC system's counter outputs and the host link, for example a UART or AXI-Stream bridge. A snapshot starts on an explicit request or on a programmable periodic timer.

---
 rtl/ber_stats_pkg.sv | 24 ++
 rtl/ber_stats_timer.sv | 31 +++
 rtl/ber_stats_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ber_stats_pkg.sv
// Shared types and constants for the BER statistics snapshot reader.
// STATS_CHECKSUM_EN adds the CSUM state used for the trailing checksum word.
package ber_stats_pkg;

  localparam logic [15:0] STATS_MAGIC  = 16'hB5E7;
  localparam int          N_COUNTERS   = 5;
  localparam int          N_DATA_WORDS = 10;

`ifdef STATS_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } stats_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } stats_state_t;
`endif

endpackage

// File: rtl/ber_stats_timer.sv
// Periodic tick generator; a new period_cycles is adopted only when the count wraps.
module ber_stats_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] period_cycles,
  output logic        tick
);

  logic [31:0] cur_period;
  logic [31:0] cnt;

  assign tick = (period_cycles != 32'd0) && (cur_period != 32'd0) &&
                (cnt == cur_period - 32'd1);

  // cur_period of zero means "not yet loaded", so the first nonzero period loads immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_period <= '0;
      cnt        <= '0;
    end else if (period_cycles == 32'd0) begin
      cur_period <= '0;
      cnt        <= '0;
    end else if ((cur_period == 32'd0) || tick) begin
      cur_period <= period_cycles;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ber_stats_reader.sv
// Captures the five 64-bit BER counters and streams them as a framed word sequence.
// Define STATS_CHECKSUM_EN to append an XOR checksum word to every frame.
module ber_stats_reader
  import ber_stats_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       total_bits,
  input  logic [63:0]       total_bit_errors_pre,
  input  logic [63:0]       total_bit_errors_post,
  input  logic [63:0]       total_frames,
  input  logic [63:0]       total_frame_errors,
  input  logic              snap_req,
  input  logic [31:0]       period_cycles,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       overrun_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(N_DATA_WORDS - 1);
`ifdef STATS_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  stats_state_t                 state;
  logic [3:0]                   idx;
  logic [SEQ_W-1:0]             seq;
  logic                         pending;
  logic [N_DATA_WORDS-1:0][31:0] snap_words;

  logic timer_tick;
  logic req;
  logic handshake;
  logic finish;
  logic capture;

  ber_stats_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .period_cycles (period_cycles),
    .tick          (timer_tick)
  );

  assign req       = snap_req | timer_tick;
  assign handshake = out_valid & out_ready;
`ifdef STATS_CHECKSUM_EN
  assign finish    = handshake && (state == ST_CSUM);
`else
  assign finish    = handshake && (state == ST_DATA) && (idx == LAST_IDX);
`endif
  assign capture   = ((state == ST_IDLE) && req) || (finish && (pending || req));

  // Snapshot register ordered as it is streamed: each counter high word, then low word
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_words <= '0;
    end else if (capture) begin
      snap_words[0] <= total_bits[63:32];
      snap_words[1] <= total_bits[31:0];
      snap_words[2] <= total_bit_errors_pre[63:32];
      snap_words[3] <= total_bit_errors_pre[31:0];
      snap_words[4] <= total_bit_errors_post[63:32];
      snap_words[5] <= total_bit_errors_post[31:0];
      snap_words[6] <= total_frames[63:32];
      snap_words[7] <= total_frames[31:0];
      snap_words[8] <= total_frame_errors[63:32];
      snap_words[9] <= total_frame_errors[31:0];
    end
  end

`ifdef STATS_CHECKSUM_EN
  logic [31:0] csum;

  // Running XOR of the header and data words already handed downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (capture) begin
      csum <= '0;
    end else if (handshake && ((state == ST_HDR) || (state == ST_DATA))) begin
      csum <= csum ^ out_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      seq         <= '0;
      pending     <= 1'b0;
      overrun_cnt <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state     <= ST_HDR;
            out_data  <= {STATS_MAGIC, seq};
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_HDR: begin
          if (handshake) begin
            state    <= ST_DATA;
            idx      <= '0;
            out_data <= snap_words[0];
            out_last <= 1'b0;
          end
        end
        ST_DATA: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
`ifdef STATS_CHECKSUM_EN
              state    <= ST_CSUM;
              out_data <= csum ^ out_data;
              out_last <= 1'b1;
`endif
            end else begin
              idx      <= idx + 4'd1;
              out_data <= snap_words[idx + 4'd1];
              out_last <= !CSUM_EN && (idx == LAST_IDX - 4'd1);
            end
          end
        end
        default: begin
        end
      endcase

      // End of frame: a waiting or coincident request chains straight into the next header
      if (finish) begin
        seq     <= seq + 1'b1;
        pending <= 1'b0;
        if (pending || req) begin
          state    <= ST_HDR;
          out_data <= {STATS_MAGIC, seq + 1'b1};
          out_last <= 1'b0;
        end else begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      end else if (req && (state != ST_IDLE)) begin
        if (!pending) begin
          pending <= 1'b1;
        end else if (overrun_cnt != 16'hFFFF) begin
          overrun_cnt <= overrun_cnt + 16'd1;
        end
      end
    end
  end

endmodule
